// File: rtl/i2c_slave.sv
// i2c_slave: I2C target with a 7-bit address that hands write bytes to a host and fetches read bytes from it
// Ports:
//   pclk, prst          system clock; asynchronous active-high reset
//   scl                 bus clock from the master (input only, never stretched)
//   sda                 open-drain bus data: driven 0 or released to z
//   rx_data, rx_valid   last byte written by the master; one-pclk strobe on update
//   rx_ready            host can accept a byte: ACK (1) or NACK (0) for write bytes
//   tx_data, tx_req     byte returned on the next read byte; one-pclk strobe when captured
//   busy, rw            address matched and transfer in progress; R/W bit of that transfer
module i2c_slave #(
    parameter logic [6:0] SLV_ADDR = 7'h50
) (
    input  logic       pclk,
    input  logic       prst,
    input  logic       scl,
    inout  wire        sda,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy,
    output logic       rw
);
    typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP} state_t;
    state_t     r_state, w_state;
    logic [1:0] r_scl_s, r_sda_s;
    logic       r_scl_d, r_sda_d;
    logic [3:0] r_cnt, w_cnt;
    logic [7:0] r_sr, w_sr, w_rx_data;
    logic       r_oe, w_oe, w_rx_valid, w_tx_req, w_busy, w_rw, w_load;
    logic       w_scl, w_sda, w_rise, w_fall, w_start, w_stop;
    assign w_scl   = r_scl_s[1];
    assign w_sda   = r_sda_s[1];
    assign w_rise  = w_scl & ~r_scl_d;
    assign w_fall  = ~w_scl & r_scl_d;
    // START/STOP need scl high on both samples so an sda change right at an scl edge is not misread
    assign w_start = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign w_stop  = w_scl & r_scl_d & ~r_sda_d & w_sda;
    // reset gates the driver combinationally so the bus is freed in the same cycle
    assign sda = (r_oe & ~prst) ? 1'b0 : 1'bz;
    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            r_scl_s  <= 2'b11;
            r_sda_s  <= 2'b11;
            r_scl_d  <= 1'b1;
            r_sda_d  <= 1'b1;
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            r_sr     <= 8'h00;
            r_oe     <= 1'b0;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            busy     <= 1'b0;
            rw       <= 1'b0;
        end else begin
            r_scl_s  <= {r_scl_s[0], scl};
            r_sda_s  <= {r_sda_s[0], sda};
            r_scl_d  <= w_scl;
            r_sda_d  <= w_sda;
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_sr     <= w_sr;
            r_oe     <= w_oe;
            rx_data  <= w_rx_data;
            rx_valid <= w_rx_valid;
            tx_req   <= w_tx_req;
            busy     <= w_busy;
            rw       <= w_rw;
        end
    end
    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_sr       = r_sr;
        w_oe       = r_oe;
        w_rx_data  = rx_data;
        w_rx_valid = 1'b0;
        w_tx_req   = 1'b0;
        w_busy     = busy;
        w_rw       = rw;
        w_load     = 1'b0;
        if (w_start) begin
            w_state = ADDR;
            w_cnt   = 4'd0;
            w_sr    = 8'h00;
            w_oe    = 1'b0;
        end else if (w_stop) begin
            w_state = IDLE;
            w_cnt   = 4'd0;
            w_oe    = 1'b0;
            w_busy  = 1'b0;
        end else begin
            case (r_state)
                ADDR, WR_DATA: begin
                    if (w_rise) begin
                        w_sr  = {r_sr[6:0], w_sda};
                        w_cnt = r_cnt + 4'd1;
                    end else if (w_fall && r_cnt == 4'd8) begin
                        w_cnt = 4'd0;
                        if (r_state == WR_DATA) begin
                            w_rx_data  = r_sr;
                            w_rx_valid = 1'b1;
                            w_state    = WR_ACK;
                            w_oe       = rx_ready;
                        end else if (r_sr[7:1] == SLV_ADDR) begin
                            w_rw    = r_sr[0];
                            w_busy  = 1'b1;
                            w_state = ADDR_ACK;
                            w_oe    = 1'b1;
                        end else begin
                            w_busy  = 1'b0;
                            w_state = WAIT_STOP;
                        end
                    end
                end
                // ACK states are entered on an scl fall, so the next fall ends bit 9
                ADDR_ACK: if (w_fall) begin
                    w_load  = rw;
                    w_state = WR_DATA;
                    w_oe    = 1'b0;
                end
                WR_ACK: if (w_fall) begin
                    w_state = r_oe ? WR_DATA : WAIT_STOP;
                    w_oe    = 1'b0;
                end
                RD_DATA: begin
                    if (w_rise) begin
                        w_cnt = r_cnt + 4'd1;
                    end else if (w_fall) begin
                        if (r_cnt == 4'd8) begin
                            w_oe    = 1'b0;
                            w_state = RD_ACK;
                        end else begin
                            w_sr = {r_sr[6:0], 1'b0};
                            w_oe = ~r_sr[6];
                        end
                    end
                end
                // master ACK is remembered as cnt=9 and acted on at the following fall
                RD_ACK: begin
                    if (w_rise) begin
                        if (w_sda) w_state = WAIT_STOP;
                        else w_cnt = 4'd9;
                    end else if (w_fall && r_cnt == 4'd9) begin
                        w_load = 1'b1;
                    end
                end
                default: ;
            endcase
            if (w_load) begin
                w_state  = RD_DATA;
                w_sr     = tx_data;
                w_oe     = ~tx_data[7];
                w_tx_req = 1'b1;
                w_cnt    = 4'd0;
            end
        end
    end
endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: directed bench for i2c_slave acting as an I2C master on an open-drain bus
`timescale 1ns/1ps
module tb_i2c_slave;
    localparam time Q = 200ns;
    logic       pclk = 1'b0;
    logic       prst = 1'b1;
    logic       scl = 1'b1;
    logic       m_rel = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic [7:0] rx_data;
    logic       rx_valid, tx_req, busy, rw;
    wire        sda;
    int n_cmp = 0, n_err = 0;
    int n_rxv = 0, n_txr = 0, n_low = 0, n_both = 0;
    int s_rxv, s_txr, s_low;
    logic       ack;
    logic [7:0] d;
    assign sda = m_rel ? 1'bz : 1'b0;
    pullup (sda);
    always #5 pclk = ~pclk;
    i2c_slave #(.SLV_ADDR(7'h50)) dut (
        .pclk(pclk), .prst(prst), .scl(scl), .sda(sda),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_req(tx_req), .busy(busy), .rw(rw)
    );
    always @(posedge pclk) begin
        if (rx_valid) n_rxv <= n_rxv + 1;
        if (tx_req) n_txr <= n_txr + 1;
        if (rx_valid && tx_req) n_both <= n_both + 1;
        if (m_rel && sda === 1'b0) n_low <= n_low + 1;
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic xbit(input logic b, output logic s);
        m_rel = b; #(Q); scl = 1'b1; #(Q); s = sda; #(Q); scl = 1'b0; #(Q);
    endtask
    task automatic start_c;
        m_rel = 1'b1; #(Q); scl = 1'b1; #(Q); m_rel = 1'b0; #(Q); scl = 1'b0; #(Q);
    endtask
    task automatic stop_c;
        m_rel = 1'b0; #(Q); scl = 1'b1; #(Q); m_rel = 1'b1; #(Q); #(Q);
    endtask
    task automatic wbyte(input logic [7:0] b, output logic a);
        logic s;
        for (int i = 7; i >= 0; i--) xbit(b[i], s);
        xbit(1'b1, a);
    endtask
    task automatic rbyte(input logic mack, output logic [7:0] v);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            xbit(1'b1, s);
            v[i] = s;
        end
        xbit(mack, s);
    endtask
    task automatic snap;
        s_rxv = n_rxv; s_txr = n_txr; s_low = n_low;
    endtask
    initial begin
        #53;
        chk("rst_sda", 32'(sda), 32'(1'b1));
        chk("rst_rx_data", 32'(rx_data), 32'h00);
        chk("rst_rx_valid", 32'(rx_valid), 32'(1'b0));
        chk("rst_tx_req", 32'(tx_req), 32'(1'b0));
        chk("rst_busy", 32'(busy), 32'(1'b0));
        chk("rst_rw", 32'(rw), 32'(1'b0));
        prst = 1'b0;
        #(Q);
        // write A0, 3C
        snap();
        start_c();
        wbyte(8'hA0, ack);
        chk("wr_addr_ack", 32'(ack), 32'(1'b0));
        chk("wr_busy", 32'(busy), 32'(1'b1));
        chk("wr_rw", 32'(rw), 32'(1'b0));
        wbyte(8'h3C, ack);
        chk("wr_data_ack", 32'(ack), 32'(1'b0));
        chk("wr_rx_data", 32'(rx_data), 32'h3C);
        chk("wr_rxv_count", 32'(n_rxv - s_rxv), 32'd1);
        stop_c();
        chk("wr_busy_stop", 32'(busy), 32'(1'b0));
        // read 96, 5A
        snap();
        tx_data = 8'h96;
        start_c();
        wbyte(8'hA1, ack);
        chk("rd_addr_ack", 32'(ack), 32'(1'b0));
        chk("rd_rw", 32'(rw), 32'(1'b1));
        chk("rd_txreq1", 32'(n_txr - s_txr), 32'd1);
        tx_data = 8'h5A;
        rbyte(1'b0, d);
        chk("rd_byte1", 32'(d), 32'h96);
        chk("rd_txreq2", 32'(n_txr - s_txr), 32'd2);
        tx_data = 8'hFF;
        rbyte(1'b1, d);
        chk("rd_byte2", 32'(d), 32'h5A);
        chk("rd_sda_rel", 32'(sda), 32'(1'b1));
        stop_c();
        chk("rd_txreq_end", 32'(n_txr - s_txr), 32'd2);
        chk("rd_busy_stop", 32'(busy), 32'(1'b0));
        // address miss
        snap();
        start_c();
        wbyte(8'hA2, ack);
        chk("miss_addr_nack", 32'(ack), 32'(1'b1));
        chk("miss_busy", 32'(busy), 32'(1'b0));
        wbyte(8'h11, ack);
        stop_c();
        chk("miss_sda_low", 32'(n_low - s_low), 32'd0);
        chk("miss_rxv", 32'(n_rxv - s_rxv), 32'd0);
        chk("miss_busy_end", 32'(busy), 32'(1'b0));
        // flow control NACK
        snap();
        rx_ready = 1'b0;
        start_c();
        wbyte(8'hA0, ack);
        chk("fc_addr_ack", 32'(ack), 32'(1'b0));
        wbyte(8'h77, ack);
        chk("fc_nack", 32'(ack), 32'(1'b1));
        chk("fc_rx_data", 32'(rx_data), 32'h77);
        chk("fc_rxv", 32'(n_rxv - s_rxv), 32'd1);
        rx_ready = 1'b1;
        wbyte(8'h55, ack);
        chk("fc_ignored_ack", 32'(ack), 32'(1'b1));
        chk("fc_ignored_rxv", 32'(n_rxv - s_rxv), 32'd1);
        chk("fc_ignored_data", 32'(rx_data), 32'h77);
        stop_c();
        // repeated START
        snap();
        start_c();
        wbyte(8'hA0, ack);
        wbyte(8'h01, ack);
        chk("rs_wr_ack", 32'(ack), 32'(1'b0));
        tx_data = 8'hC3;
        start_c();
        wbyte(8'hA1, ack);
        chk("rs_addr_ack", 32'(ack), 32'(1'b0));
        chk("rs_rw", 32'(rw), 32'(1'b1));
        rbyte(1'b1, d);
        chk("rs_rd_byte", 32'(d), 32'hC3);
        stop_c();
        chk("rs_rx_data", 32'(rx_data), 32'h01);
        chk("rs_rxv", 32'(n_rxv - s_rxv), 32'd1);
        chk("rs_txreq", 32'(n_txr - s_txr), 32'd1);
        // reset during bit 4 of a read of 00 (slave holds sda low every bit)
        tx_data = 8'h00;
        start_c();
        wbyte(8'hA1, ack);
        for (int i = 0; i < 3; i++) xbit(1'b1, ack);
        m_rel = 1'b1; #(Q); scl = 1'b1; #(Q);
        chk("mr_sda_driven", 32'(sda), 32'(1'b0));
        prst = 1'b1;
        #1;
        chk("mr_sda_released", 32'(sda), 32'(1'b1));
        #20;
        chk("mr_rx_data", 32'(rx_data), 32'h00);
        chk("mr_busy", 32'(busy), 32'(1'b0));
        chk("mr_rw", 32'(rw), 32'(1'b0));
        chk("mr_tx_req", 32'(tx_req), 32'(1'b0));
        chk("mr_rx_valid", 32'(rx_valid), 32'(1'b0));
        prst = 1'b0;
        #(Q); scl = 1'b0; #(Q);
        snap();
        start_c();
        wbyte(8'hA0, ack);
        chk("mr_wr_addr_ack", 32'(ack), 32'(1'b0));
        wbyte(8'h5E, ack);
        chk("mr_wr_data_ack", 32'(ack), 32'(1'b0));
        stop_c();
        chk("mr_wr_rx_data", 32'(rx_data), 32'h5E);
        chk("mr_wr_rxv", 32'(n_rxv - s_rxv), 32'd1);
        chk("no_rxv_txreq_overlap", 32'(n_both), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 SHALL have parameter SLV_ADDR, default 7'h50: the 7-bit target address this block answers to.
REQ-002 SHALL have port pclk, input, 1: the single system clock; all logic runs on its rising edge.
REQ-003 SHALL have port prst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port scl, input, 1: I2C clock from the bus master; this block never drives or stretches it.
REQ-005 SHALL have port sda, inout, 1: open-drain I2C data; the block drives 1'b0 or releases it to 1'bz, never 1'b1.
REQ-006 SHALL have port rx_data, output, 8: the last byte written by the master.
REQ-007 SHALL have port rx_valid, output, 1: one-pclk pulse when rx_data is updated.
REQ-008 SHALL have port rx_ready, input, 1: the host can accept a byte; it selects ACK or NACK for write bytes.
REQ-009 SHALL have port tx_data, input, 8: the byte to return on the next read byte.
REQ-010 SHALL have port tx_req, output, 1: one-pclk pulse when tx_data is captured; the host then presents the next byte.
REQ-011 SHALL have port busy, output, 1: high from an address match until STOP or return to IDLE.
REQ-012 SHALL have port rw, output, 1: the R/W bit of the current addressed transfer (1 = read).

Function
REQ-013 SHALL pass scl and sda through a 2-flop synchronizer and derive scl rise, scl fall, START and STOP from the synchronized values; pclk SHALL be at least 10x the SCL frequency.
REQ-014 SHALL detect START as a synchronized sda falling edge while scl is high, and STOP as a synchronized sda rising edge while scl is high.
REQ-015 SHALL sample bus bits on scl rise and change sda only on scl fall; data is MSB first.
REQ-016 SHALL implement the states IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK and WAIT_STOP.
REQ-017 SHALL go from IDLE, or from any other state, to ADDR on START and clear the bit counter (repeated START included).
REQ-018 SHALL, in ADDR, shift in 8 bits; on the 8th-bit match of addr[7:1]==SLV_ADDR it SHALL latch rw, set busy and go to ADDR_ACK at the next scl fall; on mismatch it SHALL go to WAIT_STOP with sda released.
REQ-019 SHALL, in ADDR_ACK, drive sda low from the scl fall after bit 8 to the scl fall after bit 9, then go to WR_DATA (rw=0) or RD_DATA (rw=1).
REQ-020 SHALL, on entry to RD_DATA, capture tx_data into the shift register and pulse tx_req for exactly one pclk.
REQ-021 SHALL, in WR_DATA, shift in 8 bits; at the scl fall after bit 8 it SHALL load rx_data, pulse rx_valid once, and enter WR_ACK.
REQ-022 SHALL, in WR_ACK, drive sda low if rx_ready was 1 at that scl fall (ACK) and release sda otherwise (NACK).
REQ-023 SHALL leave WR_ACK at the scl fall after bit 9: to WR_DATA after ACK, to WAIT_STOP after NACK.
REQ-024 SHALL, in RD_DATA, drive sda low for 0 bits and release it for 1 bits across 8 bits, then release sda and enter RD_ACK.
REQ-025 SHALL, in RD_ACK, sample the master's bit on scl rise: 0 (ACK) → RD_DATA with a new tx_data capture and tx_req pulse; 1 (NACK) → WAIT_STOP.
REQ-026 SHALL, in WAIT_STOP, keep sda released and ignore bus bits until START or STOP.
REQ-027 SHALL, on STOP in any state, release sda, clear busy, go to IDLE and emit no rx_valid for a partial byte.
REQ-028 SHALL give START priority over a same-cycle scl edge, and SHALL discard a partial byte on START.
REQ-029 SHALL never have rx_valid and tx_req high in the same cycle.

Reset
REQ-030 SHALL, while prst=1, hold state IDLE, sda released, rx_data=8'h00, rx_valid=0, tx_req=0, busy=0, rw=0, synchronizer flops at 1, and the counter and shift register at 0.
REQ-031 SHALL, on prst asserted mid-transfer, release sda within the same cycle (asynchronously), and after release SHALL wait for a new START.

Verification
REQ-032 SHALL verify a write: START, 0xA0, 0x3C, STOP with rx_ready=1 → ACK on both 9th clocks, one rx_valid with rx_data=8'h3C, busy 1→0 at STOP.
REQ-033 SHALL verify a read: START, 0xA1 with tx_data=8'h96 then 8'h5A, master ACK then NACK, STOP → bytes 96h and 5Ah seen on sda, two tx_req pulses, sda released after the NACK.
REQ-034 SHALL verify an address miss: START, 0xA2, 0x11, STOP → sda never low, no rx_valid, busy stays 0.
REQ-035 SHALL verify flow control: write 0x77 with rx_ready=0 → NACK at the 9th clock, rx_valid still pulses with 8'h77, then WAIT_STOP and the next byte is ignored.
REQ-036 SHALL verify a repeated START: START, 0xA0, 0x01, rSTART, 0xA1, read 1 byte with NACK, STOP → rx_data=8'h01, rw=1 after the rSTART, one tx_req.
REQ-037 SHALL verify reset mid-read: prst pulsed during bit 4 of RD_DATA → sda released immediately, all outputs at reset values, and a following full write is received correctly.
